mem_port_arbiter: RTL and testbench

- Shares one single-ported, variable-latency backing memory between the instruction-fetch port (IF stage, read-only) and the data port (MEM stage, read/write).
- Serialises the two requesters with a grant FSM and talks to the memory over a req/ack handshake.
- Drives stall_o, which freezes the PC, IF_ID and downstream pipeline registers until every pending access of the current pipeline step has completed.

---
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between the IF fetch port and
// the MEM data port. DM has fixed priority. stall_o holds the pipeline until both ports are served.
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT  = 16,
   parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic [31:0] if_data_o,
   output logic        if_ready_o,
   input  logic        dm_req_i,
   input  logic        dm_we_i,
   input  logic [31:0] dm_addr_i,
   input  logic [31:0] dm_wdata_i,
   output logic [31:0] dm_rdata_o,
   output logic        dm_ready_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_ack_i,
   output logic        stall_o,
   output logic        err_o
);

   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, GNT_IF, GNT_DM} state_t;

   state_t        state_q, state_d;
   logic          served_if_q, served_if_d;
   logic          served_dm_q, served_dm_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_we_q, mem_we_d;
   logic [31:0]   mem_addr_q, mem_addr_d;
   logic [31:0]   mem_wdata_q, mem_wdata_d;
   logic [31:0]   if_data_q, if_data_d;
   logic [31:0]   dm_rdata_q, dm_rdata_d;
   logic          if_ready_q, if_ready_d;
   logic          dm_ready_q, dm_ready_d;
   logic          err_q, err_d;

   logic          pend_if, pend_dm, stall;
   logic          done;
   logic [31:0]   rd_data;

   assign pend_if = if_req_i & ~served_if_q;
   assign pend_dm = dm_req_i & ~served_dm_q;
   assign stall   = pend_if | pend_dm | (state_q != IDLE);

   always_comb begin
      state_d     = state_q;
      served_if_d = served_if_q;
      served_dm_d = served_dm_q;
      cnt_d       = cnt_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_data_d   = if_data_q;
      dm_rdata_d  = dm_rdata_q;
      if_ready_d  = 1'b0;
      dm_ready_d  = 1'b0;
      err_d       = err_q;
      done        = 1'b0;
      rd_data     = ERR_DATA;

      // The pipeline advances on every non-stalled edge, so held requests become fresh ones.
      if (!stall) begin
         served_if_d = 1'b0;
         served_dm_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (pend_dm) begin
               state_d     = GNT_DM;
               mem_req_d   = 1'b1;
               mem_we_d    = dm_we_i;
               mem_addr_d  = dm_addr_i;
               mem_wdata_d = dm_wdata_i;
               cnt_d       = '0;
            end else if (pend_if) begin
               state_d     = GNT_IF;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = if_addr_i;
               mem_wdata_d = 32'h0;
               cnt_d       = '0;
            end
         end
         GNT_IF, GNT_DM: begin
            cnt_d   = cnt_q + 1'b1;
            done    = mem_ack_i | (cnt_q == CNT_LAST);
            rd_data = mem_ack_i ? mem_rdata_i : ERR_DATA;
            if (done) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               if (!mem_ack_i) begin
                  err_d = 1'b1;
               end
               if (state_q == GNT_IF) begin
                  if_data_d   = rd_data;
                  if_ready_d  = 1'b1;
                  served_if_d = 1'b1;
               end else begin
                  if (!mem_we_q) begin
                     dm_rdata_d = rd_data;
                  end
                  dm_ready_d  = 1'b1;
                  served_dm_d = 1'b1;
               end
            end
         end
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         served_if_q <= 1'b0;
         served_dm_q <= 1'b0;
         cnt_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
         if_data_q   <= 32'h0;
         dm_rdata_q  <= 32'h0;
         if_ready_q  <= 1'b0;
         dm_ready_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         served_if_q <= served_if_d;
         served_dm_q <= served_dm_d;
         cnt_q       <= cnt_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_data_q   <= if_data_d;
         dm_rdata_q  <= dm_rdata_d;
         if_ready_q  <= if_ready_d;
         dm_ready_q  <= dm_ready_d;
         err_q       <= err_d;
      end
   end

   // The freeze is forced low during reset so every output reads 0 while rst_n_i is asserted.
   assign stall_o     = rst_n_i & stall;
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign if_data_o   = if_data_q;
   assign dm_rdata_o  = dm_rdata_q;
   assign if_ready_o  = if_ready_q;
   assign dm_ready_o  = dm_ready_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a cycle-by-cycle vector table for the
// basic accesses plus hand-written timeout and mid-grant reset sequences.
module tb_mem_port_arbiter;

   logic        clock;
   logic        resetN;
   logic        ifReq;
   logic [31:0] ifAddr;
   logic [31:0] ifData;
   logic        ifReady;
   logic        dmReq;
   logic        dmWe;
   logic [31:0] dmAddr;
   logic [31:0] dmWdata;
   logic [31:0] dmRdata;
   logic        dmReady;
   logic        memReq;
   logic        memWe;
   logic [31:0] memAddr;
   logic [31:0] memWdata;
   logic [31:0] memRdata;
   logic        memAck;
   logic        stall;
   logic        err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        ifReq;
      logic [31:0] ifAddr;
      logic        dmReq;
      logic        dmWe;
      logic [31:0] dmAddr;
      logic [31:0] dmWdata;
      logic        memAck;
      logic [31:0] memRdata;
      logic        expMemReq;
      logic        expMemWe;
      logic [31:0] expMemAddr;
      logic [31:0] expMemWdata;
      logic        expIfReady;
      logic        expDmReady;
      logic        expStall;
      logic [31:0] expIfData;
      logic [31:0] expDmRdata;
      logic        expErr;
   } vector_t;

   vector_t vecs[$];

   mem_port_arbiter #(.TIMEOUT(16), .ERR_DATA(32'h0000_0000)) dut (
      .clk_i      (clock),
      .rst_n_i    (resetN),
      .if_req_i   (ifReq),
      .if_addr_i  (ifAddr),
      .if_data_o  (ifData),
      .if_ready_o (ifReady),
      .dm_req_i   (dmReq),
      .dm_we_i    (dmWe),
      .dm_addr_i  (dmAddr),
      .dm_wdata_i (dmWdata),
      .dm_rdata_o (dmRdata),
      .dm_ready_o (dmReady),
      .mem_req_o  (memReq),
      .mem_we_o   (memWe),
      .mem_addr_o (memAddr),
      .mem_wdata_o(memWdata),
      .mem_rdata_i(memRdata),
      .mem_ack_i  (memAck),
      .stall_o    (stall),
      .err_o      (err)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Hard stop in case the stimulus ever stalls on a clock wait.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vector_t makeVec(
      input logic ifr, input logic [31:0] ifa, input logic dmr, input logic we,
      input logic [31:0] dma, input logic [31:0] wd, input logic ack, input logic [31:0] rd,
      input logic eReq, input logic eWe, input logic [31:0] eAddr, input logic [31:0] eWd,
      input logic eIfRdy, input logic eDmRdy, input logic eStall,
      input logic [31:0] eIfData, input logic [31:0] eDmRdata, input logic eErr);
      vector_t v;
      v.ifReq = ifr;        v.ifAddr = ifa;        v.dmReq = dmr;        v.dmWe = we;
      v.dmAddr = dma;       v.dmWdata = wd;        v.memAck = ack;       v.memRdata = rd;
      v.expMemReq = eReq;   v.expMemWe = eWe;      v.expMemAddr = eAddr; v.expMemWdata = eWd;
      v.expIfReady = eIfRdy; v.expDmReady = eDmRdy; v.expStall = eStall;
      v.expIfData = eIfData; v.expDmRdata = eDmRdata; v.expErr = eErr;
      return v;
   endfunction

   task automatic applyStimulus(input vector_t v);
      ifReq    = v.ifReq;
      ifAddr   = v.ifAddr;
      dmReq    = v.dmReq;
      dmWe     = v.dmWe;
      dmAddr   = v.dmAddr;
      dmWdata  = v.dmWdata;
      memAck   = v.memAck;
      memRdata = v.memRdata;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic checkVector(input int idx, input vector_t v);
      checkOutput($sformatf("v%0d mem_req", idx),   32'(memReq),   32'(v.expMemReq));
      checkOutput($sformatf("v%0d mem_we", idx),    32'(memWe),    32'(v.expMemWe));
      checkOutput($sformatf("v%0d mem_addr", idx),  memAddr,       v.expMemAddr);
      checkOutput($sformatf("v%0d mem_wdata", idx), memWdata,      v.expMemWdata);
      checkOutput($sformatf("v%0d if_ready", idx),  32'(ifReady),  32'(v.expIfReady));
      checkOutput($sformatf("v%0d dm_ready", idx),  32'(dmReady),  32'(v.expDmReady));
      checkOutput($sformatf("v%0d stall", idx),     32'(stall),    32'(v.expStall));
      checkOutput($sformatf("v%0d if_data", idx),   ifData,        v.expIfData);
      checkOutput($sformatf("v%0d dm_rdata", idx),  dmRdata,       v.expDmRdata);
      checkOutput($sformatf("v%0d err", idx),       32'(err),      32'(v.expErr));
   endtask

   task automatic clearInputs();
      ifReq = 1'b0; ifAddr = 32'h0; dmReq = 1'b0; dmWe = 1'b0;
      dmAddr = 32'h0; dmWdata = 32'h0; memAck = 1'b0; memRdata = 32'h0;
   endtask

   // Main sequence: inputs change 1 time unit after a rising edge, outputs are checked on the falling edge.
   initial begin
      int highCycles;

      clearInputs();
      resetN = 1'b0;
      repeat (3) @(negedge clock);
      checkOutput("reset mem_req", 32'(memReq), 32'h0);
      checkOutput("reset stall",   32'(stall),  32'h0);
      checkOutput("reset err",     32'(err),    32'h0);
      checkOutput("reset if_data", ifData,      32'h0);
      resetN = 1'b1;

      // IF read with two wait cycles
      vecs.push_back(makeVec(1,32'h40,0,0,0,0,0,0,                 0,0,32'h0,0,  0,0,1, 32'h0,0,0));
      vecs.push_back(makeVec(1,32'h40,0,0,0,0,0,0,                 1,0,32'h40,0, 0,0,1, 32'h0,0,0));
      vecs.push_back(makeVec(1,32'h40,0,0,0,0,0,0,                 1,0,32'h40,0, 0,0,1, 32'h0,0,0));
      vecs.push_back(makeVec(1,32'h40,0,0,0,0,1,32'h8C010004,      1,0,32'h40,0, 0,0,1, 32'h0,0,0));
      vecs.push_back(makeVec(1,32'h40,0,0,0,0,0,0,                 0,0,32'h40,0, 1,0,0, 32'h8C010004,0,0));
      vecs.push_back(makeVec(0,32'h40,0,0,0,0,0,0,                 0,0,32'h40,0, 0,0,0, 32'h8C010004,0,0));
      // Simultaneous IF 0x44 and DM read 0x100; the idle-cycle ack must be ignored
      vecs.push_back(makeVec(1,32'h44,1,0,32'h100,0,1,32'hDEAD0000, 0,0,32'h40,0,  0,0,1, 32'h8C010004,0,0));
      vecs.push_back(makeVec(1,32'h44,1,0,32'h100,0,1,32'h11112222, 1,0,32'h100,0, 0,0,1, 32'h8C010004,0,0));
      vecs.push_back(makeVec(1,32'h44,1,0,32'h100,0,0,0,            0,0,32'h100,0, 0,1,1, 32'h8C010004,32'h11112222,0));
      vecs.push_back(makeVec(1,32'h44,1,0,32'h100,0,1,32'h33334444, 1,0,32'h44,0,  0,0,1, 32'h8C010004,32'h11112222,0));
      vecs.push_back(makeVec(1,32'h44,1,0,32'h100,0,0,0,            0,0,32'h44,0,  1,0,0, 32'h33334444,32'h11112222,0));
      // New fetch after the stall episode ends
      vecs.push_back(makeVec(1,32'h48,0,0,0,0,0,0,                  0,0,32'h44,0,  0,0,1, 32'h33334444,32'h11112222,0));
      vecs.push_back(makeVec(1,32'h48,0,0,0,0,1,32'h55556666,       1,0,32'h48,0,  0,0,1, 32'h33334444,32'h11112222,0));
      vecs.push_back(makeVec(0,32'h48,0,0,0,0,0,0,                  0,0,32'h48,0,  1,0,0, 32'h55556666,32'h11112222,0));
      // DM write keeps the previous read data
      vecs.push_back(makeVec(0,0,1,1,32'h10,32'h5,0,0,              0,0,32'h48,0,  0,0,1, 32'h55556666,32'h11112222,0));
      vecs.push_back(makeVec(0,0,1,1,32'h10,32'h5,0,0,              1,1,32'h10,5,  0,0,1, 32'h55556666,32'h11112222,0));
      vecs.push_back(makeVec(0,0,1,1,32'h10,32'h5,1,32'hFFFFFFFF,   1,1,32'h10,5,  0,0,1, 32'h55556666,32'h11112222,0));
      vecs.push_back(makeVec(0,0,0,0,0,0,0,0,                       0,0,32'h10,5,  0,1,0, 32'h55556666,32'h11112222,0));
      vecs.push_back(makeVec(0,0,0,0,0,0,0,0,                       0,0,32'h10,5,  0,0,0, 32'h55556666,32'h11112222,0));

      foreach (vecs[i]) begin
         @(posedge clock); #1;
         applyStimulus(vecs[i]);
         @(negedge clock);
         checkVector(i, vecs[i]);
      end

      // Timeout: DM read at 0x200 never acknowledged
      @(posedge clock); #1;
      clearInputs();
      dmReq = 1'b1; dmAddr = 32'h200;
      @(negedge clock);
      checkOutput("timeout stall before grant", 32'(stall), 32'h1);
      highCycles = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clock); #1;
         @(negedge clock);
         if (memReq) highCycles++;
         else break;
      end
      checkOutput("timeout mem_req cycles", 32'(highCycles), 32'd16);
      checkOutput("timeout dm_ready",       32'(dmReady),    32'h1);
      checkOutput("timeout dm_rdata",       dmRdata,         32'h0);
      checkOutput("timeout err",            32'(err),        32'h1);
      @(posedge clock); #1;
      dmReq = 1'b0;
      @(negedge clock);
      checkOutput("timeout dm_ready one cycle", 32'(dmReady), 32'h0);

      // A good IF access afterwards leaves err set
      @(posedge clock); #1;
      ifReq = 1'b1; ifAddr = 32'h80;
      @(posedge clock); #1;
      memAck = 1'b1; memRdata = 32'hABCD1234;
      @(negedge clock);
      checkOutput("post-timeout mem_addr", memAddr, 32'h80);
      @(posedge clock); #1;
      memAck = 1'b0; ifReq = 1'b0;
      @(negedge clock);
      checkOutput("post-timeout if_ready", 32'(ifReady), 32'h1);
      checkOutput("post-timeout if_data",  ifData,       32'hABCD1234);
      checkOutput("post-timeout err sticky", 32'(err),   32'h1);

      // Reset asserted between edges while a DM read is granted
      @(posedge clock); #1;
      dmReq = 1'b1; dmAddr = 32'h300; dmWe = 1'b0;
      @(posedge clock); #1;
      @(negedge clock);
      checkOutput("pre-reset mem_req", 32'(memReq), 32'h1);
      checkOutput("pre-reset mem_addr", memAddr,    32'h300);
      #2;
      resetN = 1'b0;
      #1;
      checkOutput("mid-reset mem_req",  32'(memReq),  32'h0);
      checkOutput("mid-reset stall",    32'(stall),   32'h0);
      checkOutput("mid-reset dm_ready", 32'(dmReady), 32'h0);
      checkOutput("mid-reset if_ready", 32'(ifReady), 32'h0);
      checkOutput("mid-reset err",      32'(err),     32'h0);
      dmReq = 1'b0; ifReq = 1'b1; ifAddr = 32'h400;
      @(negedge clock); #1;
      resetN = 1'b1;
      @(posedge clock); #1;
      checkOutput("post-reset mem_req",  32'(memReq), 32'h1);
      checkOutput("post-reset mem_addr", memAddr,     32'h400);
      checkOutput("post-reset mem_we",   32'(memWe),  32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
